// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline WB stage and a
// buffered long-latency unit, with a destination scoreboard and starvation stall.
module regfile_wb_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pipe_we,
  input  logic [AWIDTH-1:0]               pipe_addr,
  input  logic [DWIDTH-1:0]               pipe_data,
  input  logic                            lu_valid,
  output logic                            lu_ready,
  input  logic [AWIDTH-1:0]               lu_addr,
  input  logic [DWIDTH-1:0]               lu_data,
  input  logic                            issue_valid,
  input  logic                            issue_long,
  input  logic [AWIDTH-1:0]               issue_dst,
  output logic [31:0]                     busy_vec,
  output logic                            wb_stall,
  output logic                            rf_we,
  output logic [AWIDTH-1:0]               rf_addr,
  output logic [DWIDTH-1:0]               rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AGW-1:0] LIMIT_C = AGW'(STARVE_LIMIT);

  logic [AWIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DWIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [AGW-1:0]    age_reg;
  logic [31:0]       busy_bits;

  logic              pipe_win;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;
  logic [AWIDTH-1:0] head_addr;
  logic [DWIDTH-1:0] head_data;

  // Pop eligibility uses the registered count, so a fresh push can never bypass.
  assign fifo_nonempty = (count_reg != '0);
  assign pipe_win      = pipe_we && (pipe_addr != '0);
  assign pop           = !pipe_win && fifo_nonempty;
  assign lu_ready      = rst_n && (count_reg < DEPTH_C);
  assign push          = lu_valid && lu_ready;
  assign head_addr     = mem_addr[rd_ptr_reg];
  assign head_data     = mem_data[rd_ptr_reg];
  assign wb_stall      = fifo_nonempty && (age_reg >= LIMIT_C);
  assign fifo_count    = count_reg;
  assign busy_vec      = busy_bits;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= lu_addr;
      mem_data[wr_ptr_reg] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_reg <= '0;
    end else if (!fifo_nonempty || pop) begin
      age_reg <= '0;
    end else if (age_reg < LIMIT_C) begin
      age_reg <= age_reg + 1'b1;
    end
  end

  // A popped head destined for r0 is consumed but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else if (pipe_win) begin
      rf_we    <= 1'b1;
      rf_addr  <= pipe_addr;
      rf_wdata <= pipe_data;
    end else if (pop) begin
      rf_we    <= (head_addr != '0);
      rf_addr  <= head_addr;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_bits[gi] = 1'b0;
      end else begin : g_bit
        logic bit_reg;
        logic set_hit;
        logic clr_hit;
        assign set_hit = issue_valid && issue_long && (issue_dst == AWIDTH'(gi));
        assign clr_hit = pop && (head_addr == AWIDTH'(gi));
        // Set dominates so a re-issue in the retire cycle stays tracked.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       bit_reg <= 1'b0;
          else if (set_hit) bit_reg <= 1'b1;
          else if (clr_hit) bit_reg <= 1'b0;
        end
        assign busy_bits[gi] = bit_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with an external register file model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_dst;
  logic [31:0] busy_vec;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf_model [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_dst(issue_dst),
    .busy_vec(busy_vec), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  // Register file commits on the negedge following the registered write.
  always @(negedge clk) begin
    if (rf_we && rf_addr != 5'd0) rf_model[rf_addr] <= rf_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end else begin
      $display("check %s: 0x%08h ok", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check_val({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    check_val({tag, "_addr"}, {27'd0, rf_addr}, {27'd0, a});
    check_val({tag, "_data"}, rf_wdata, d);
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_we = 0; pipe_addr = 0; pipe_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
    issue_valid = 0; issue_long = 0; issue_dst = 0;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_val("idle_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("idle_busy", busy_vec, 32'd0);
    check_val("idle_ready", {31'd0, lu_ready}, 32'd1);
    check_val("idle_count", {30'd0, fifo_count}, 32'd0);
    check_val("idle_stall", {31'd0, wb_stall}, 32'd0);

    // Pipeline write to r5, then a dropped write to r0
    pipe_we = 1; pipe_addr = 5; pipe_data = 32'hDEADBEEF;
    tick();
    pipe_we = 0;
    check_rf("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk); #1;
    check_val("rf_model5", rf_model[5], 32'hDEADBEEF);
    pipe_we = 1; pipe_addr = 0; pipe_data = 32'h00001234;
    tick();
    pipe_we = 0;
    check_rf("pipe0_hold", 1'b0, 5'd5, 32'hDEADBEEF);

    // Long op to r7: scoreboard set, push, pop, clear
    issue_valid = 1; issue_long = 1; issue_dst = 7;
    tick();
    issue_valid = 0; issue_long = 0;
    check_val("busy7_set", busy_vec, 32'h0000_0080);
    tick(); tick();
    lu_valid = 1; lu_addr = 7; lu_data = 32'h12345678;
    tick();
    lu_valid = 0;
    check_val("lu7_count", {30'd0, fifo_count}, 32'd1);
    check_val("lu7_busy_held", busy_vec, 32'h0000_0080);
    check_val("lu7_no_bypass", {31'd0, rf_we}, 32'd0);
    tick();
    check_rf("lu7_wr", 1'b1, 5'd7, 32'h12345678);
    check_val("busy7_clr", busy_vec, 32'd0);
    check_val("lu7_empty", {30'd0, fifo_count}, 32'd0);

    // Pipeline hogs the port while two results buffer up; starvation stall
    pipe_we = 1; pipe_addr = 20; pipe_data = 32'h100;
    lu_valid = 1; lu_addr = 8; lu_data = 32'hA;
    tick();
    check_val("fill1_count", {30'd0, fifo_count}, 32'd1);
    lu_addr = 9; lu_data = 32'hB;
    tick();
    check_val("fill2_count", {30'd0, fifo_count}, 32'd2);
    check_val("fill2_ready", {31'd0, lu_ready}, 32'd0);
    check_val("fill2_stall", {31'd0, wb_stall}, 32'd0);
    lu_addr = 10; lu_data = 32'hC;
    tick(); tick();
    check_val("age3_stall", {31'd0, wb_stall}, 32'd0);
    check_rf("pipe20", 1'b1, 5'd20, 32'h100);
    tick();
    check_val("age4_stall", {31'd0, wb_stall}, 32'd1);
    check_val("held_count", {30'd0, fifo_count}, 32'd2);
    lu_valid = 0; pipe_we = 0;
    tick();
    check_rf("drain8", 1'b1, 5'd8, 32'hA);
    check_val("drain8_count", {30'd0, fifo_count}, 32'd1);
    check_val("drain8_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    check_rf("drain9", 1'b1, 5'd9, 32'hB);
    check_val("drain9_count", {30'd0, fifo_count}, 32'd0);

    // Set-wins on same-cycle issue/pop, and push+pop at count 1
    pipe_we = 1; pipe_addr = 21; pipe_data = 32'h200;
    issue_valid = 1; issue_long = 1; issue_dst = 9;
    tick();
    issue_dst = 12;
    tick();
    issue_valid = 0; issue_long = 0;
    lu_valid = 1; lu_addr = 9; lu_data = 32'h99;
    tick();
    lu_addr = 12; lu_data = 32'h12;
    tick();
    check_val("sb_busy", busy_vec, 32'h0000_1200);
    check_val("sb_full", {30'd0, fifo_count}, 32'd2);
    pipe_we = 0;
    lu_addr = 13; lu_data = 32'h13;
    issue_valid = 1; issue_long = 1; issue_dst = 9;
    tick();
    issue_valid = 0; issue_long = 0;
    check_rf("pop9", 1'b1, 5'd9, 32'h99);
    check_val("pop9_count", {30'd0, fifo_count}, 32'd1);
    check_val("setwins_busy", busy_vec, 32'h0000_1200);
    tick();
    lu_valid = 0;
    check_rf("pop12", 1'b1, 5'd12, 32'h12);
    check_val("pushpop_count", {30'd0, fifo_count}, 32'd1);
    check_val("pop12_busy", busy_vec, 32'h0000_0200);
    tick();
    check_rf("pop13", 1'b1, 5'd13, 32'h13);
    check_val("pop13_count", {30'd0, fifo_count}, 32'd0);

    // FIFO head addressed to r0 pops without a write
    lu_valid = 1; lu_addr = 0; lu_data = 32'h55;
    tick();
    lu_valid = 0;
    check_val("r0_push_count", {30'd0, fifo_count}, 32'd1);
    tick();
    check_val("r0_pop_we", {31'd0, rf_we}, 32'd0);
    check_val("r0_pop_count", {30'd0, fifo_count}, 32'd0);

    // Asynchronous reset with two entries buffered
    pipe_we = 1; pipe_addr = 22; pipe_data = 32'h300;
    issue_valid = 1; issue_long = 1; issue_dst = 14;
    lu_valid = 1; lu_addr = 14; lu_data = 32'h14;
    tick();
    issue_valid = 0; issue_long = 0;
    lu_addr = 15; lu_data = 32'h15;
    tick();
    lu_valid = 0;
    check_val("prerst_count", {30'd0, fifo_count}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_count", {30'd0, fifo_count}, 32'd0);
    check_val("rst_ready", {31'd0, lu_ready}, 32'd0);
    check_val("rst_busy", busy_vec, 32'd0);
    check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    pipe_we = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_count", {30'd0, fifo_count}, 32'd0);
    check_val("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("post_rst_ready", {31'd0, lu_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
